// File: rtl/riscv_ram_ctrl.sv
// riscv_ram_ctrl
//   Byte-addressed RV32 memory with an instruction-fetch port and a data
//   load/store port. Each port runs its own IDLE -> BUSY -> RESP FSM and
//   answers LATENCY cycles after a request is accepted.
//
//   Handshake (both ports): a request is accepted on a rising clk edge where
//   req & ready are both high. ready is high in IDLE and RESP, so a new
//   request can be accepted in the same cycle the previous valid is shown.
//   valid is a one-cycle pulse; rdata/err are meaningful only while valid is
//   high and otherwise hold their last value.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   i_req/i_addr             fetch request and byte address
//   i_ready/i_valid/i_rdata  fetch accept, response pulse, fetched word
//   d_req/d_we/d_addr        data request, store flag, byte address
//   d_funct3/d_wdata         RV32 load/store funct3, LSB-aligned store data
//   d_ready/d_valid          data accept, response pulse
//   d_rdata/d_err            extended load result (0 for stores/errors), error flag
module riscv_ram_ctrl #(
  parameter int    WORD_LENGTH = 32,
  parameter int    ADDR_LENGTH = 10,
  parameter int    LATENCY     = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_req,
  input  logic [WORD_LENGTH-1:0] i_addr,
  output logic                   i_ready,
  output logic                   i_valid,
  output logic [WORD_LENGTH-1:0] i_rdata,
  input  logic                   d_req,
  input  logic                   d_we,
  input  logic [WORD_LENGTH-1:0] d_addr,
  input  logic [2:0]             d_funct3,
  input  logic [WORD_LENGTH-1:0] d_wdata,
  output logic                   d_ready,
  output logic                   d_valid,
  output logic [WORD_LENGTH-1:0] d_rdata,
  output logic                   d_err
);

  localparam int DEPTH = 2 ** ADDR_LENGTH;
  // Countdown holds LATENCY-2 at accept; BUSY ends when it reaches zero.
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 1) ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  logic [WORD_LENGTH-1:0] mem [DEPTH];

  logic [ADDR_LENGTH-1:0] i_idx, d_idx;
  assign i_idx = i_addr[ADDR_LENGTH+1:2];
  assign d_idx = d_addr[ADDR_LENGTH+1:2];

  // Address bits above the word index wrap; fetch byte offset is ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[WORD_LENGTH-1:ADDR_LENGTH+2], i_addr[1:0],
                              d_addr[WORD_LENGTH-1:ADDR_LENGTH+2]};

  // ---------------- fetch port ----------------
  state_t                 i_state, i_state_nxt;
  logic [CW-1:0]          i_cnt;
  logic [WORD_LENGTH-1:0] i_pend;
  logic                   i_accept;

  assign i_ready  = (i_state != S_BUSY);
  assign i_valid  = (i_state == S_RESP);
  assign i_accept = i_req & i_ready;

  always_comb begin
    i_state_nxt = i_state;
    case (i_state)
      S_IDLE, S_RESP: begin
        if (i_accept) i_state_nxt = (LATENCY == 1) ? S_RESP : S_BUSY;
        else          i_state_nxt = S_IDLE;
      end
      S_BUSY:  if (i_cnt == '0) i_state_nxt = S_RESP;
      default: i_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_state <= S_IDLE;
      i_cnt   <= '0;
      i_pend  <= '0;
      i_rdata <= '0;
    end else begin
      i_state <= i_state_nxt;
      if (i_accept) begin
        i_cnt  <= CNT_INIT;
        i_pend <= mem[i_idx];
        if (LATENCY == 1) i_rdata <= mem[i_idx];
      end else if (i_state == S_BUSY) begin
        if (i_cnt == '0) i_rdata <= i_pend;
        else             i_cnt   <= i_cnt - 1'b1;
      end
    end
  end

  // ---------------- data port ----------------
  state_t                 d_state, d_state_nxt;
  logic [CW-1:0]          d_cnt;
  logic [WORD_LENGTH:0]   d_pend;     // {err, rdata}
  logic                   d_accept;
  logic [WORD_LENGTH-1:0] d_word, d_shift, d_load, d_wdat;
  logic [15:0]            d_half;
  logic [3:0]             d_be;
  logic                   d_err_now;

  assign d_ready  = (d_state != S_BUSY);
  assign d_valid  = (d_state == S_RESP);
  assign d_accept = d_req & d_ready;

  always_comb begin
    d_word    = mem[d_idx];
    d_shift   = d_word >> {d_addr[1:0], 3'b000};
    d_half    = d_addr[1] ? d_word[31:16] : d_word[15:0];
    d_err_now = 1'b0;
    d_load    = '0;
    d_be      = 4'b0000;
    d_wdat    = d_wdata;

    case (d_funct3[1:0])
      2'd1:    if (d_addr[0])          d_err_now = 1'b1;
      2'd2:    if (d_addr[1:0] != 2'b00) d_err_now = 1'b1;
      default: ;
    endcase
    if (d_we) begin
      if (d_funct3 > 3'd2) d_err_now = 1'b1;
    end else begin
      if (d_funct3 == 3'd3 || d_funct3[2:1] == 2'b11) d_err_now = 1'b1;
    end

    case (d_funct3)
      3'd0:    d_load = {{24{d_shift[7]}}, d_shift[7:0]};
      3'd1:    d_load = {{16{d_half[15]}}, d_half};
      3'd2:    d_load = d_word;
      3'd4:    d_load = {24'h0, d_shift[7:0]};
      3'd5:    d_load = {16'h0, d_half};
      default: d_load = '0;
    endcase
    if (d_we || d_err_now) d_load = '0;

    // Store data is replicated across lanes; byte enables pick the lanes.
    case (d_funct3[1:0])
      2'd0:    begin d_be = 4'b0001 << d_addr[1:0];            d_wdat = {4{d_wdata[7:0]}};  end
      2'd1:    begin d_be = d_addr[1] ? 4'b1100 : 4'b0011;     d_wdat = {2{d_wdata[15:0]}}; end
      2'd2:    begin d_be = 4'b1111;                            d_wdat = d_wdata;            end
      default: begin d_be = 4'b0000;                            d_wdat = d_wdata;            end
    endcase
    if (!d_we || d_err_now) d_be = 4'b0000;
  end

  always_comb begin
    d_state_nxt = d_state;
    case (d_state)
      S_IDLE, S_RESP: begin
        if (d_accept) d_state_nxt = (LATENCY == 1) ? S_RESP : S_BUSY;
        else          d_state_nxt = S_IDLE;
      end
      S_BUSY:  if (d_cnt == '0) d_state_nxt = S_RESP;
      default: d_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_state <= S_IDLE;
      d_cnt   <= '0;
      d_pend  <= '0;
      d_rdata <= '0;
      d_err   <= 1'b0;
    end else begin
      d_state <= d_state_nxt;
      if (d_accept) begin
        d_cnt  <= CNT_INIT;
        d_pend <= {d_err_now, d_load};
        if (LATENCY == 1) {d_err, d_rdata} <= {d_err_now, d_load};
      end else if (d_state == S_BUSY) begin
        if (d_cnt == '0) {d_err, d_rdata} <= d_pend;
        else             d_cnt <= d_cnt - 1'b1;
      end
    end
  end

  // Nonblocking write at the accept edge: same-edge readers see old data.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (d_accept && !rst && d_be[b]) mem[d_idx][8*b +: 8] <= d_wdat[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_riscv_ram_ctrl.sv
module tb_riscv_ram_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance a: LATENCY=1, 1 KiW.  Instance b: LATENCY=3, 16 words (aliasing).
  logic        a_rst, a_i_req, a_i_ready, a_i_valid, a_d_req, a_d_we, a_d_ready, a_d_valid, a_d_err;
  logic [31:0] a_i_addr, a_i_rdata, a_d_addr, a_d_wdata, a_d_rdata;
  logic [2:0]  a_d_funct3;
  logic        b_rst, b_i_req, b_i_ready, b_i_valid, b_d_req, b_d_we, b_d_ready, b_d_valid, b_d_err;
  logic [31:0] b_i_addr, b_i_rdata, b_d_addr, b_d_wdata, b_d_rdata;
  logic [2:0]  b_d_funct3;

  riscv_ram_ctrl #(.WORD_LENGTH(32), .ADDR_LENGTH(10), .LATENCY(1)) dut_a (
    .clk(clk), .rst(a_rst),
    .i_req(a_i_req), .i_addr(a_i_addr), .i_ready(a_i_ready), .i_valid(a_i_valid), .i_rdata(a_i_rdata),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_funct3(a_d_funct3), .d_wdata(a_d_wdata),
    .d_ready(a_d_ready), .d_valid(a_d_valid), .d_rdata(a_d_rdata), .d_err(a_d_err)
  );

  riscv_ram_ctrl #(.WORD_LENGTH(32), .ADDR_LENGTH(4), .LATENCY(3)) dut_b (
    .clk(clk), .rst(b_rst),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_ready(b_i_ready), .i_valid(b_i_valid), .i_rdata(b_i_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_funct3(b_d_funct3), .d_wdata(b_d_wdata),
    .d_ready(b_d_ready), .d_valid(b_d_valid), .d_rdata(b_d_rdata), .d_err(b_d_err)
  );

  // ---------------- scoreboard ----------------
  logic [32:0] a_dq[$];   // {err, rdata}
  logic [31:0] a_iq[$];
  logic [32:0] b_dq[$];
  logic [31:0] b_iq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic a_data(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic exp_err,
                        input logic [31:0] exp_data, input string tag);
    logic [32:0] e;
    int lat;
    @(negedge clk);
    chk({tag, " ready"}, 64'(a_d_ready), 64'd1);
    a_d_req = 1'b1; a_d_we = we; a_d_funct3 = f3; a_d_addr = addr; a_d_wdata = wdata;
    a_dq.push_back({exp_err, exp_data});
    @(negedge clk);
    a_d_req = 1'b0;
    lat = 1;
    while (!a_d_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " valid"}, 64'(a_d_valid), 64'd1);
    chk({tag, " latency"}, 64'(lat), 64'd1);
    if (a_d_valid && a_dq.size() > 0) begin
      e = a_dq.pop_front();
      chk({tag, " err"}, 64'(a_d_err), 64'(e[32]));
      chk({tag, " rdata"}, 64'(a_d_rdata), 64'(e[31:0]));
      @(negedge clk);
      chk({tag, " pulse"}, 64'(a_d_valid), 64'd0);
      chk({tag, " hold"}, 64'(a_d_rdata), 64'(e[31:0]));
    end
  endtask

  task automatic a_fetch(input logic [31:0] addr, input logic [31:0] exp_data, input string tag);
    int lat;
    @(negedge clk);
    a_i_req = 1'b1; a_i_addr = addr;
    a_iq.push_back(exp_data);
    @(negedge clk);
    a_i_req = 1'b0;
    lat = 1;
    while (!a_i_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " valid"}, 64'(a_i_valid), 64'd1);
    chk({tag, " latency"}, 64'(lat), 64'd1);
    if (a_i_valid && a_iq.size() > 0) chk({tag, " rdata"}, 64'(a_i_rdata), 64'(a_iq.pop_front()));
  endtask

  task automatic b_data(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_data, input string tag);
    logic [32:0] e;
    int lat;
    @(negedge clk);
    b_d_req = 1'b1; b_d_we = we; b_d_funct3 = f3; b_d_addr = addr; b_d_wdata = wdata;
    b_dq.push_back({1'b0, exp_data});
    @(negedge clk);
    b_d_req = 1'b0;
    chk({tag, " busy ready"}, 64'(b_d_ready), 64'd0);
    lat = 1;
    while (!b_d_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " valid"}, 64'(b_d_valid), 64'd1);
    chk({tag, " latency"}, 64'(lat), 64'd3);
    if (b_d_valid && b_dq.size() > 0) begin
      e = b_dq.pop_front();
      chk({tag, " err"}, 64'(b_d_err), 64'(e[32]));
      chk({tag, " rdata"}, 64'(b_d_rdata), 64'(e[31:0]));
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1ms;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] ra, rd;
    a_rst = 1'b1; a_i_req = 1'b0; a_i_addr = '0; a_d_req = 1'b0; a_d_we = 1'b0;
    a_d_addr = '0; a_d_funct3 = '0; a_d_wdata = '0;
    b_rst = 1'b1; b_i_req = 1'b0; b_i_addr = '0; b_d_req = 1'b0; b_d_we = 1'b0;
    b_d_addr = '0; b_d_funct3 = '0; b_d_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0;

    // Reset state
    chk("rst a_i_valid", 64'(a_i_valid), 64'd0);
    chk("rst a_d_valid", 64'(a_d_valid), 64'd0);
    chk("rst a_i_rdata", 64'(a_i_rdata), 64'd0);
    chk("rst a_d_rdata", 64'(a_d_rdata), 64'd0);
    chk("rst a_d_err",   64'(a_d_err),   64'd0);
    chk("rst a_ready",   64'({a_i_ready, a_d_ready}), 64'd3);
    chk("rst b_ready",   64'({b_i_ready, b_d_ready}), 64'd3);
    chk("rst b_valid",   64'({b_i_valid, b_d_valid}), 64'd0);

    // Word store/load
    a_data(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0,        "sw10");
    a_data(1'b0, 3'd2, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF, "lw10");

    // Sign/zero extension
    a_data(1'b1, 3'd2, 32'h30, 32'h8081F0FF, 1'b0, 32'h0,        "sw30");
    a_data(1'b0, 3'd0, 32'h30, 32'h0,        1'b0, 32'hFFFFFFFF, "lb30");
    a_data(1'b0, 3'd4, 32'h31, 32'h0,        1'b0, 32'h000000F0, "lbu31");
    a_data(1'b0, 3'd1, 32'h32, 32'h0,        1'b0, 32'hFFFF8081, "lh32");
    a_data(1'b0, 3'd5, 32'h32, 32'h0,        1'b0, 32'h00008081, "lhu32");
    a_data(1'b0, 3'd0, 32'h33, 32'h0,        1'b0, 32'hFFFFFF80, "lb33");
    a_data(1'b0, 3'd5, 32'h30, 32'h0,        1'b0, 32'h0000F0FF, "lhu30");

    // Byte enables
    a_data(1'b1, 3'd2, 32'h20, 32'h0,        1'b0, 32'h0,        "sw20");
    a_data(1'b1, 3'd0, 32'h21, 32'hFFFFFFAA, 1'b0, 32'h0,        "sb21");
    a_data(1'b1, 3'd1, 32'h22, 32'hFFFF1234, 1'b0, 32'h0,        "sh22");
    a_data(1'b0, 3'd2, 32'h20, 32'h0,        1'b0, 32'h1234AA00, "lw20");

    // Errors
    a_data(1'b1, 3'd2, 32'h04, 32'hCAFEF00D, 1'b0, 32'h0,        "sw04");
    a_data(1'b0, 3'd2, 32'h06, 32'h0,        1'b1, 32'h0,        "lw06 err");
    a_data(1'b0, 3'd2, 32'h04, 32'h0,        1'b0, 32'hCAFEF00D, "lw04");
    a_data(1'b1, 3'd2, 32'h00, 32'h01020304, 1'b0, 32'h0,        "sw00");
    a_data(1'b1, 3'd1, 32'h03, 32'hFFFFFFFF, 1'b1, 32'h0,        "sh03 err");
    a_data(1'b1, 3'd2, 32'h02, 32'hFFFFFFFF, 1'b1, 32'h0,        "sw02 err");
    a_data(1'b1, 3'd4, 32'h00, 32'hFFFFFFFF, 1'b1, 32'h0,        "st f3=4 err");
    a_data(1'b0, 3'd3, 32'h00, 32'h0,        1'b1, 32'h0,        "ld f3=3 err");
    a_data(1'b0, 3'd6, 32'h00, 32'h0,        1'b1, 32'h0,        "ld f3=6 err");
    a_data(1'b0, 3'd1, 32'h01, 32'h0,        1'b1, 32'h0,        "lh01 err");
    a_data(1'b0, 3'd2, 32'h00, 32'h0,        1'b0, 32'h01020304, "lw00 unchanged");

    // Fetch, including ignored byte offset and address wrap
    a_fetch(32'h10,       32'hDEADBEEF, "if10");
    a_fetch(32'h13,       32'hDEADBEEF, "if13");
    a_fetch(32'h0000_1020, 32'h1234AA00, "if wrap");

    // Same-edge fetch and store: fetch sees old data
    a_data(1'b1, 3'd2, 32'h40, 32'h11111111, 1'b0, 32'h0, "sw40 old");
    @(negedge clk);
    a_i_req = 1'b1; a_i_addr = 32'h40;
    a_d_req = 1'b1; a_d_we = 1'b1; a_d_funct3 = 3'd2; a_d_addr = 32'h40; a_d_wdata = 32'h22222222;
    a_iq.push_back(32'h11111111);
    a_dq.push_back({1'b0, 32'h0});
    @(negedge clk);
    a_i_req = 1'b0; a_d_req = 1'b0;
    chk("same i_valid", 64'(a_i_valid), 64'd1);
    chk("same d_valid", 64'(a_d_valid), 64'd1);
    if (a_i_valid && a_iq.size() > 0) chk("same i_rdata old", 64'(a_i_rdata), 64'(a_iq.pop_front()));
    if (a_d_valid && a_dq.size() > 0) chk("same d_rdata", 64'({a_d_err, a_d_rdata}), 64'(a_dq.pop_front()));
    a_fetch(32'h40, 32'h22222222, "if40 new");

    // Random word round trips
    for (int n = 0; n < 6; n++) begin
      ra = {22'h0, 8'($urandom_range(64, 127)), 2'b00};
      rd = $urandom;
      a_data(1'b1, 3'd2, ra, rd, 1'b0, 32'h0, "rnd sw");
      a_data(1'b0, 3'd2, ra, 32'h0, 1'b0, rd, "rnd lw");
      a_fetch(ra, rd, "rnd if");
    end

    // LATENCY=3 instance, ADDR_LENGTH=4: 0x40 aliases 0x00
    b_data(1'b1, 3'd2, 32'h40, 32'h5A5A5A5A, 32'h0,        "b sw40");
    b_data(1'b0, 3'd2, 32'h00, 32'h0,        32'h5A5A5A5A, "b lw00 alias");

    // Fetch held high: valid every third cycle, ready low in BUSY
    @(negedge clk);
    b_i_req = 1'b1; b_i_addr = 32'h0;
    for (int k = 0; k < 3; k++) b_iq.push_back(32'h5A5A5A5A);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk($sformatf("b stream valid k=%0d", k), 64'(b_i_valid), 64'((k % 3) == 2));
      chk($sformatf("b stream ready k=%0d", k), 64'(b_i_ready), 64'((k % 3) == 2));
      if (b_i_valid && b_iq.size() > 0) chk("b stream rdata", 64'(b_i_rdata), 64'(b_iq.pop_front()));
    end
    chk("b stream drained", 64'(b_iq.size()), 64'd0);

    // Reset during BUSY drops the pending fetch
    @(negedge clk);
    chk("b busy ready", 64'(b_i_ready), 64'd0);
    b_rst = 1'b1; b_i_req = 1'b0;
    @(negedge clk);
    b_rst = 1'b0;
    chk("b rst ready",  64'(b_i_ready), 64'd1);
    chk("b rst valid",  64'(b_i_valid), 64'd0);
    chk("b rst rdata",  64'(b_i_rdata), 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("b dropped no valid", 64'(b_i_valid), 64'd0);
    end

    // Memory survives reset
    b_data(1'b0, 3'd2, 32'h00, 32'h0, 32'h5A5A5A5A, "b lw after rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
